// File: rtl/led_chaser_pkg.sv
// Package: led_chaser_pkg
// Shared definitions for the led_chaser LED pattern generator.
//   mode_e     : pattern mode encodings (L->R dot, R->L dot, ping-pong dot, bar fill/clear)
//   dir_e      : ping-pong travel direction
//   phase_e    : bar mode phase (filling from MSB or clearing from MSB)
//   start_value: pattern value a mode starts from (and returns to on wrap)
package led_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_L2R  = 2'b00,
        MODE_R2L  = 2'b01,
        MODE_PING = 2'b10,
        MODE_FILL = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        PH_FILL  = 1'b0,
        PH_CLEAR = 1'b1
    } phase_e;

    // Widest LED bank the start-value helper can describe; callers size-cast the result.
    localparam int unsigned MAX_LED = 64;

    // Start value: LSB dot for R->L, MSB dot for every other mode.
    function automatic logic [MAX_LED-1:0] start_value(input mode_e m, input int unsigned n_led);
        logic [MAX_LED-1:0] v;
        if (m == MODE_R2L) begin
            v = {{(MAX_LED-1){1'b0}}, 1'b1};
        end else begin
            v = {{(MAX_LED-1){1'b0}}, 1'b1} << (n_led - 32'd1);
        end
        return v;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Module: led_prescaler
// Step-rate prescaler: produces a tick every step_div_i+1 enabled clocks.
//   clk        in   system clock
//   reset      in   synchronous active-high reset (cnt <= 0)
//   en_i       in   1 = count, 0 = freeze counter, no tick
//   clr_i      in   synchronous restart of the count (used on mode change)
//   step_div_i in   clocks per step minus 1, sampled every cycle
//   tick_o     out  combinational: en_i && cnt >= step_div_i
module led_prescaler
#(
    parameter int DIV_W = 24
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] step_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // ">=" rather than "==" so lowering step_div below the running count ticks
    // on the next enabled cycle instead of wrapping the whole counter.
    assign tick_o = en_i && (cnt_q >= step_div_i);

    // Next count: restart on clear or tick, advance when enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (tick_o) begin
            cnt_d = {DIV_W{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {DIV_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser.sv
// Module: led_chaser
// N-bit LED pattern generator with runtime step-rate prescaler and four modes.
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   en         in   1 = run, 0 = freeze pattern and prescaler
//   mode       in   00 L->R dot, 01 R->L dot, 10 ping-pong dot, 11 bar fill/clear
//   step_div   in   clocks per step minus 1
//   led        out  LED drive (registered pattern)
//   step       out  1-cycle pulse on each pattern advance
//   cycle_done out  1-cycle pulse when the pattern returns to its mode start value
// Build option: define LED_CHASER_ACTIVE_LOW_EN to drive led inverted (active-low boards).
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int N_LED = 8,
    parameter int DIV_W = 24
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] step_div,
    output logic [N_LED-1:0] led,
    output logic             step,
    output logic             cycle_done
);

    localparam logic [N_LED-1:0] MSB_ONE  = {1'b1, {(N_LED-1){1'b0}}};
    localparam logic [N_LED-1:0] LSB_ONE  = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] ALL_ONES = {N_LED{1'b1}};
    localparam logic [N_LED-1:0] ALL_ZERO = {N_LED{1'b0}};

    mode_e            mode_in_s;
    mode_e            mode_q;
    logic [N_LED-1:0] pat_q,   pat_d;
    dir_e             dir_q,   dir_d;
    phase_e           phase_q, phase_d;
    logic             step_q,  step_d;
    logic             done_q,  done_d;
    logic             tick_s;
    logic             mode_chg_s;
    logic [N_LED-1:0] start_new_s;
    logic [N_LED-1:0] start_cur_s;
    logic [N_LED-1:0] adv_pat_s;
    dir_e             adv_dir_s;
    phase_e           adv_phase_s;

    assign mode_in_s   = mode_e'(mode);
    assign mode_chg_s  = (mode_in_s != mode_q);
    assign start_new_s = N_LED'(start_value(mode_in_s, N_LED));
    assign start_cur_s = N_LED'(start_value(mode_q, N_LED));

    led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en),
        .clr_i      (mode_chg_s),
        .step_div_i (step_div),
        .tick_o     (tick_s)
    );

    // Pattern value, direction and phase that one advance in the current mode would produce.
    always_comb begin
        adv_pat_s   = pat_q;
        adv_dir_s   = dir_q;
        adv_phase_s = phase_q;
        case (mode_q)
            MODE_L2R: begin
                if (pat_q == LSB_ONE) begin
                    adv_pat_s = MSB_ONE;
                end else begin
                    adv_pat_s = pat_q >> 1;
                end
            end
            MODE_R2L: begin
                if (pat_q == MSB_ONE) begin
                    adv_pat_s = LSB_ONE;
                end else begin
                    adv_pat_s = pat_q << 1;
                end
            end
            MODE_PING: begin
                // Direction turns as the dot lands on an end, so each end is shown once.
                if (dir_q == DIR_DOWN) begin
                    adv_pat_s = pat_q >> 1;
                    if (adv_pat_s[0]) begin
                        adv_dir_s = DIR_UP;
                    end else begin
                        adv_dir_s = DIR_DOWN;
                    end
                end else begin
                    adv_pat_s = pat_q << 1;
                    if (adv_pat_s[N_LED-1]) begin
                        adv_dir_s = DIR_DOWN;
                    end else begin
                        adv_dir_s = DIR_UP;
                    end
                end
            end
            MODE_FILL: begin
                if (phase_q == PH_FILL) begin
                    adv_pat_s = (pat_q >> 1) | MSB_ONE;
                    if (adv_pat_s == ALL_ONES) begin
                        adv_phase_s = PH_CLEAR;
                    end else begin
                        adv_phase_s = PH_FILL;
                    end
                end else begin
                    if (pat_q == ALL_ZERO) begin
                        adv_pat_s   = MSB_ONE;
                        adv_phase_s = PH_FILL;
                    end else begin
                        adv_pat_s   = pat_q >> 1;
                        adv_phase_s = PH_CLEAR;
                    end
                end
            end
            default: begin
                adv_pat_s   = pat_q;
                adv_dir_s   = dir_q;
                adv_phase_s = phase_q;
            end
        endcase
    end

    // Next state: a mode change wins over a coincident tick and produces no pulses.
    always_comb begin
        pat_d   = pat_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        if (mode_chg_s) begin
            pat_d   = start_new_s;
            dir_d   = DIR_DOWN;
            phase_d = PH_FILL;
        end else if (tick_s) begin
            pat_d   = adv_pat_s;
            dir_d   = adv_dir_s;
            phase_d = adv_phase_s;
            step_d  = 1'b1;
            done_d  = (adv_pat_s == start_cur_s) ? 1'b1 : 1'b0;
        end else begin
            pat_d   = pat_q;
            dir_d   = dir_q;
            phase_d = phase_q;
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= mode_in_s;
            pat_q   <= MSB_ONE;
            dir_q   <= DIR_DOWN;
            phase_q <= PH_FILL;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mode_q  <= mode_in_s;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign step       = step_q;
    assign cycle_done = done_q;

`ifdef LED_CHASER_ACTIVE_LOW_EN
    assign led = ~pat_q;
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_chaser.sv
module tb_led_chaser;

    localparam int N     = 8;
    localparam int DIV_W = 24;

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] step_div;
    logic [N-1:0]     led;
    logic             step;
    logic             cycle_done;

    int checks = 0;
    int errors = 0;

    // Reference model: position k within the mode's pattern sequence.
    int m_mode;
    int m_k;
    int m_cnt;
    bit m_step;
    bit m_cd;

    typedef struct {
        bit          rst;
        bit          en;
        logic [1:0]  mode;
        logic [23:0] div;
        logic [7:0]  led;
        bit          stp;
        bit          cd;
    } vec_t;

    vec_t tbl[11];

    led_chaser #(.N_LED(N), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .step_div   (step_div),
        .led        (led),
        .step       (step),
        .cycle_done (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period(input int md);
        case (md)
            0, 1:    return N;
            2:       return 2 * N - 2;
            default: return 2 * N;
        endcase
    endfunction

    // Pattern value at position k of a mode's sequence, built from shifts of constants.
    function automatic logic [N-1:0] seq_val(input int md, input int k);
        logic [N-1:0] msb;
        logic [N-1:0] one;
        logic [N-1:0] all1;
        msb  = {1'b1, {(N-1){1'b0}}};
        one  = {{(N-1){1'b0}}, 1'b1};
        all1 = {N{1'b1}};
        case (md)
            0:       return msb >> k;
            1:       return one << k;
            2:       return (k < N) ? (msb >> k) : (one << (k - N + 1));
            default: return (k < N) ? ~(all1 >> (k + 1)) : (all1 >> (k - N + 1));
        endcase
    endfunction

    function automatic logic [N-1:0] drv(input logic [N-1:0] v);
`ifdef LED_CHASER_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs the DUT sees at that edge.
    task automatic model_update();
        if (reset) begin
            m_mode = int'(mode);
            m_k    = (m_mode == 1) ? N - 1 : 0;
            m_cnt  = 0;
            m_step = 1'b0;
            m_cd   = 1'b0;
        end else if (int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_k    = 0;
            m_cnt  = 0;
            m_step = 1'b0;
            m_cd   = 1'b0;
        end else if (en && (m_cnt >= int'(step_div))) begin
            m_cnt  = 0;
            m_k    = (m_k + 1) % period(m_mode);
            m_step = 1'b1;
            m_cd   = (m_k == 0);
        end else begin
            if (en) m_cnt = m_cnt + 1;
            m_step = 1'b0;
            m_cd   = 1'b0;
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        model_update();
        #1;
        check("model_led", led, drv(seq_val(m_mode, m_k)));
        check("model_step", step, m_step);
        check("model_cycle_done", cycle_done, m_cd);
    endtask

    initial begin
        logic [N-1:0] saved;

        reset    = 1'b1;
        en       = 1'b1;
        mode     = 2'b00;
        step_div = '0;

        // T1: reset then L->R at full rate.
        tbl[0]  = '{1'b1, 1'b1, 2'b00, 24'd0, 8'h80, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'b00, 24'd0, 8'h80, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h40, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h20, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h10, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h08, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h04, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h02, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h01, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h80, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 24'd0, 8'h40, 1'b1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            reset    = tbl[i].rst;
            en       = tbl[i].en;
            mode     = tbl[i].mode;
            step_div = tbl[i].div;
            step_clk();
            check("tbl_led", led, drv(tbl[i].led));
            check("tbl_step", step, tbl[i].stp);
            check("tbl_cycle_done", cycle_done, tbl[i].cd);
        end

        // T2: R->L, one step every 4 clocks; the model checks pulse width.
        mode     = 2'b01;
        step_div = 24'd3;
        step_clk();
        check("t2_mode_load", led, drv(8'h01));
        for (int i = 0; i < 11; i++) step_clk();
        check("t2_after_12", led, drv(8'h04));

        // T3: ping-pong full rate over two bounces.
        mode     = 2'b10;
        step_div = 24'd0;
        for (int i = 0; i < 30; i++) step_clk();

        // T4: bar fill/clear full rate over two periods.
        mode = 2'b11;
        for (int i = 0; i < 36; i++) step_clk();

        // T5: mode change coinciding with a tick, then en=0 freeze.
        mode = 2'b00;
        for (int i = 0; i < 3; i++) step_clk();
        check("t5_pre_led", led, drv(8'h20));
        mode = 2'b01;
        step_clk();
        check("t5_mode_beats_tick_led", led, drv(8'h01));
        check("t5_mode_beats_tick_step", step, 1'b0);
        step_clk();
        step_clk();
        saved = led;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clk();
            check("t5_frozen_led", led, saved);
            check("t5_frozen_step", step, 1'b0);
        end

        // step_div lowered below the running count ticks on the next cycle.
        en       = 1'b1;
        step_div = 24'd10;
        for (int i = 0; i < 6; i++) step_clk();
        step_div = 24'd2;
        step_clk();
        check("div_lowered_step", step, 1'b1);

        // T6: reset in the middle of a pattern.
        mode     = 2'b00;
        step_div = 24'd0;
        for (int i = 0; i < 4; i++) step_clk();
        check("t6_mid_led", led, drv(8'h10));
        reset = 1'b1;
        step_clk();
        check("t6_reset_led", led, drv(8'h80));
        check("t6_reset_step", step, 1'b0);
        reset = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) step_div = 24'($urandom_range(0, 3));
            step_clk();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
